// File: rtl/reg_file_wb.sv
// 32-entry CPU register file: one write port, two combinational read ports and a debug port.
// Register 0 reads as zero everywhere. The optional bypass forwards same-cycle write data to the read ports.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [15:0]       wr_cnt_q;
  logic [15:0]       wr_cnt_d;
  logic              commit;
  logic              wr_live;

  assign commit  = we && (waddr != '0);
  // Forwarding must stay quiet while reset holds every read at zero.
  assign wr_live = commit && rst_n;

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (commit) begin
      regs_d[waddr] = wdata;
      if (wr_cnt_q != 16'hFFFF) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = raddr1;
  assign rd_addr[1] = raddr2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                           (BYPASS && wr_live && (waddr == rd_addr[gi])) ? wdata :
                           regs_q[rd_addr[gi]];
    end
  endgenerate

  assign rdata1   = rd_data[0];
  assign rdata2   = rd_data[1];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  assign wr_cnt   = wr_cnt_q;

  we_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(we));

endmodule

// File: tb/tb_reg_file_wb.sv
// Bench for reg_file_wb: bypassing and non-bypassing instances share one stimulus stream.
// An array model is checked on every negedge, and directed literal checks pin the model.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [4:0]  dbg_addr = '0;

  logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
  logic [15:0] cnt_b, cnt_n;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] model_mem [32];
  logic [15:0] model_cnt;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_cnt(cnt_b)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rd1_n), .raddr2(raddr2), .rdata2(rd2_n),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n), .wr_cnt(cnt_n)
  );

  // Model: plain array plus a saturating counter; register 0 never written.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_mem[i] <= '0;
      model_cnt <= '0;
    end else if (we && waddr != 5'd0) begin
      model_mem[waddr] <= wdata;
      if (model_cnt != 16'hFFFF) model_cnt <= model_cnt + 16'd1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && rst_n && we && waddr != 5'd0 && waddr == a) return wdata;
    return model_mem[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rd1_byp", rd1_b, exp_rd(raddr1, 1'b1));
    chk("rd2_byp", rd2_b, exp_rd(raddr2, 1'b1));
    chk("dbg_byp", dbg_b, exp_rd(dbg_addr, 1'b0));
    chk("cnt_byp", {16'd0, cnt_b}, {16'd0, model_cnt});
    chk("rd1_nob", rd1_n, exp_rd(raddr1, 1'b0));
    chk("rd2_nob", rd2_n, exp_rd(raddr2, 1'b0));
    chk("dbg_nob", dbg_n, exp_rd(dbg_addr, 1'b0));
    chk("cnt_nob", {16'd0, cnt_n}, {16'd0, model_cnt});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("reset_rd1", rd1_b, 32'd0);
    chk("reset_cnt", {16'd0, cnt_b}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    $display("txn: reset released");

    // Write 5 then read back; same-cycle bypass is covered by the compare process
    raddr1 = 5'd5;
    wr(5'd5, 32'hDEADBEEF);
    #1;
    chk("w5_rd1_byp", rd1_b, 32'hDEADBEEF);
    chk("w5_rd1_nob", rd1_n, 32'hDEADBEEF);
    chk("w5_cnt", {16'd0, cnt_b}, 32'd1);
    $display("txn: write r5=deadbeef cnt=%0d", cnt_b);

    // Write to register 0 is dropped and not counted
    raddr1 = 5'd0;
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    #1;
    chk("r0_byp_rd1", rd1_b, 32'd0);
    tick();
    we = 1'b0;
    #1;
    chk("r0_rd1", rd1_b, 32'd0);
    chk("r0_cnt", {16'd0, cnt_n}, 32'd1);
    $display("txn: write r0 ignored cnt=%0d", cnt_n);

    // Bypass vs. no-bypass on a read of the register being written
    wr(5'd7, 32'd1);
    raddr1 = 5'd7; raddr2 = 5'd7; dbg_addr = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'd2;
    #1;
    chk("byp_rd1", rd1_b, 32'd2);
    chk("byp_rd2", rd2_b, 32'd2);
    chk("byp_dbg", dbg_b, 32'd1);
    chk("nob_rd1", rd1_n, 32'd1);
    chk("nob_rd2", rd2_n, 32'd1);
    tick();
    we = 1'b0;
    #1;
    chk("post_rd1_nob", rd1_n, 32'd2);
    chk("post_dbg_byp", dbg_b, 32'd2);
    $display("txn: r7 1->2 byp=%h nob=%h", rd1_b, rd1_n);

    // Fill all registers, reading two different ports back
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i); dbg_addr = 5'(i);
      wr(5'(i), (32'(i) * 32'h01010101) ^ 32'hA5A50000);
      #1;
      chk("fill_dbg", dbg_n, (32'(i) * 32'h01010101) ^ 32'hA5A50000);
      $display("txn: fill r%0d=%h", i, dbg_n);
    end
    chk("fill_cnt", {16'd0, cnt_b}, 32'd34);

    // Asynchronous reset mid-run clears everything at once
    raddr1 = 5'd9; raddr2 = 5'd20; dbg_addr = 5'd31;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rd1", rd1_b, 32'd0);
    chk("arst_rd2", rd2_n, 32'd0);
    chk("arst_dbg", dbg_b, 32'd0);
    chk("arst_cnt", {16'd0, cnt_b}, 32'd0);
    $display("txn: async reset mid-run");

    // Writes are ignored and not forwarded while in reset
    tick();
    raddr1 = 5'd3; dbg_addr = 5'd3;
    we = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
    #1;
    chk("rst_nobyp", rd1_b, 32'd0);
    tick();
    chk("rst_nowr", dbg_b, 32'd0);
    chk("rst_nocnt", {16'd0, cnt_n}, 32'd0);

    // First write commits at the first edge after release
    wdata = 32'h00000033;
    rst_n = 1'b1;
    tick();
    we = 1'b0;
    #1;
    chk("first_wr", dbg_b, 32'h00000033);
    chk("first_cnt", {16'd0, cnt_b}, 32'd1);
    $display("txn: first write after reset r3=%h", dbg_b);

    // Counter saturation
    raddr1 = 5'd1; dbg_addr = 5'd1;
    we = 1'b1; waddr = 5'd1;
    for (int i = 0; i < 65537; i++) begin
      wdata = 32'(i + 100);
      tick();
      if (i == 65532) chk("sat_fffe", {16'd0, cnt_b}, 32'h0000FFFE);
    end
    we = 1'b0;
    #1;
    chk("sat_cnt_b", {16'd0, cnt_b}, 32'h0000FFFF);
    chk("sat_cnt_n", {16'd0, cnt_n}, 32'h0000FFFF);
    chk("sat_r1", rd1_b, 32'h00010064);
    $display("txn: 65537 writes to r1 cnt=%h r1=%h", cnt_b, rd1_b);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
